cpu24_ctrl_fsm: RTL and testbench



---
 rtl/cpu24_pkg.sv | 40 ++++
 rtl/cpu24_lat_counter.sv | 37 +++
 rtl/cpu24_ctrl_fsm.sv | 160 ++++++++++++++++
 tb/tb_cpu24_ctrl_fsm.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit custom-ISA core: sequencer states, PC-select
// codes, ALU operation codes and primary opcodes.
package cpu24_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  localparam logic [2:0] ALU_ADD      = 3'd0;
  localparam logic [2:0] ALU_MUL      = 3'd1;
  localparam logic [2:0] ALU_PASS     = 3'd2;
  localparam logic [2:0] ALU_ADDR_ADD = 3'd3;
  localparam logic [2:0] ALU_OR       = 3'd4;
  localparam logic [2:0] ALU_LUI      = 3'd5;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LW   = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SW   = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_LUI  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  // Width of the multi-cycle latency counter; bounds MUL_LAT to 1..15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/cpu24_lat_counter.sv
// Load/decrement latency counter for multi-cycle execute ops; done_o is high
// while the count is zero.
module cpu24_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: registers update with non-blocking assignments only; the combinational
  // block above uses blocking assignments and computes the next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cpu24_ctrl_fsm.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, handshakes with both memories, and counts retires.
module cpu24_ctrl_fsm
  import cpu24_pkg::*;
#(
  parameter int MUL_LAT = 3,  // legal 1..15
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_halt,
  input  logic [2:0]       dec_alu_op,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic lat_load;
  logic lat_done;
  logic exec_last;
  logic retire_halt;
  logic pc_we_raw;
  logic rf_we_raw;
  logic ir_we_raw;

  // The counter is preloaded while leaving DECODE so that it holds MUL_LAT-1
  // in the first EXEC cycle and reaches zero in the last one.
  assign lat_load = (state_q == S_DECODE) && !dec_halt;

  cpu24_lat_counter #(
    .W(LAT_W)
  ) u_mul_lat (
    .clk       (clk),
    .rst       (rst),
    .load_i    (lat_load),
    .load_val_i(LAT_W'(MUL_LAT - 1)),
    .dec_i     (state_q == S_EXEC),
    .done_o    (lat_done)
  );

  assign exec_last = (dec_alu_op != ALU_MUL) || lat_done;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_we_raw   = 1'b0;
    rf_we_raw   = 1'b0;
    ir_we_raw   = 1'b0;
    pc_sel      = PCSEL_SEQ;
    retire_halt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_we_raw = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_halt) begin
          retire_halt = 1'b1;
          state_d     = S_HALTED;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_last) begin
          if (dec_jump) begin
            pc_we_raw = 1'b1;
            pc_sel    = PCSEL_JMP;
            state_d   = S_FETCH;
          end else if (dec_branch) begin
            pc_we_raw = 1'b1;
            pc_sel    = alu_zero ? PCSEL_BR : PCSEL_SEQ;
            state_d   = S_FETCH;
          end else if (dec_mem_read || dec_mem_write) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (dec_mem_write) begin
            pc_we_raw = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we_raw = dec_reg_write;
        pc_we_raw = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (pc_we_raw || retire_halt) retired_d = retired_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Reset wins over a completing handshake: the datapath must not commit a
  // write at the same edge that clears the sequencer.
  assign pc_we = pc_we_raw && !rst;
  assign rf_we = rf_we_raw && !rst;
  assign ir_we = ir_we_raw && !rst;

  assign imem_req = (state_q == S_FETCH);
  assign dmem_req = (state_q == S_MEM);
  assign dmem_we  = (state_q == S_MEM) && dec_mem_write;
  assign busy     = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted   = (state_q == S_HALTED);
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_cpu24_ctrl_fsm.sv
// Randomised scoreboard bench for cpu24_ctrl_fsm: two lanes (MUL_LAT 3 and 1) each
// push per-instruction expectations from a timing model; a monitor checks retires.
module tb_cpu24_ctrl_fsm;

  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd6;
  localparam int SESSIONS = 8;
  localparam int N_PER    = 40;
  localparam int N_DIR    = 10;
  localparam int ABORT_AT = 5;
  localparam int GUARD    = 150;

  typedef struct {
    bit       rw, mr, mw, br, jp, hl;
    bit [2:0] op;
    bit       z;
    int       iw, dw;
  } instr_t;

  typedef struct {
    int       cycles;   // busy cycles from first FETCH to retire
    int       im;       // imem_req cycles
    int       dm;       // dmem_req cycles
    bit [1:0] sel;
    bit       rf;
    bit       dwe;
    bit       is_halt;
    int       ret_prev; // retired count before this instruction
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic instr_t mk(bit rw, bit mr, bit mw, bit br, bit jp, bit hl,
                                bit [2:0] op, bit z, int iw, int dw);
    instr_t i;
    i.rw = rw; i.mr = mr; i.mw = mw; i.br = br; i.jp = jp; i.hl = hl;
    i.op = op; i.z = z; i.iw = iw; i.dw = dw;
    return i;
  endfunction

  function automatic instr_t directed(int n);
    case (n)
      0:       return mk(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // ADD
      1:       return mk(1, 1, 0, 0, 0, 0, 3'd3, 0, 0, 2); // LOAD, 2 wait states
      2:       return mk(0, 0, 1, 0, 0, 0, 3'd3, 0, 0, 0); // STORE
      3:       return mk(1, 0, 0, 0, 0, 0, 3'd1, 0, 0, 0); // MUL
      4:       return mk(0, 0, 0, 1, 0, 0, 3'd0, 1, 0, 0); // BEQ taken
      5:       return mk(0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 0); // BEQ not taken
      6:       return mk(0, 0, 0, 0, 1, 0, 3'd2, 0, 0, 0); // JMP
      7:       return mk(1, 0, 0, 0, 0, 0, 3'd4, 0, 2, 0); // OR, 2 fetch waits
      8:       return mk(1, 0, 0, 0, 0, 0, 3'd7, 1, 0, 0); // undefined op
      default: return mk(0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0); // HALT
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 99);
    i = mk(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0,
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
           ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
    if ($urandom_range(0, 2) == 0) i.op = 3'd1;
    if (k < 10)      i.jp = 1;
    else if (k < 25) i.br = 1;
    else if (k < 42) i.mr = 1;
    else if (k < 57) i.mw = 1;
    else if (k < 60) i.hl = 1;
    // occasional extra flags exercise the exit priority jump > branch > memory
    if ($urandom_range(0, 7) == 0) i.mr = 1;
    if ($urandom_range(0, 7) == 0) i.mw = 1;
    if ($urandom_range(0, 9) == 0) i.br = 1;
    return i;
  endfunction

  // Timing model: phase lengths summed from the instruction's class.
  function automatic exp_t model(instr_t i, int lat, int ret);
    exp_t e;
    int   ex;
    e.ret_prev = ret;
    e.is_halt  = i.hl;
    e.im       = 1 + i.iw;
    e.dm       = 0;
    e.sel      = 2'd0;
    e.rf       = 0;
    e.dwe      = 0;
    if (i.hl) begin
      e.cycles = e.im + 1;
      return e;
    end
    ex = (i.op == 3'd1) ? lat : 1;
    if (i.jp) begin
      e.sel    = 2'd2;
      e.cycles = e.im + 1 + ex;
    end else if (i.br) begin
      e.sel    = i.z ? 2'd1 : 2'd0;
      e.cycles = e.im + 1 + ex;
    end else if (i.mr || i.mw) begin
      e.dm  = 1 + i.dw;
      e.dwe = i.mw;
      if (i.mw) begin
        e.cycles = e.im + 1 + ex + e.dm;
      end else begin
        e.cycles = e.im + 1 + ex + e.dm + 1;
        e.rf     = i.rw;
      end
    end else begin
      e.cycles = e.im + 1 + ex + 1;
      e.rf     = i.rw;
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 3 : 1;

    logic        rst, start, imem_ready, dmem_ready, alu_zero;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt;
    logic [2:0]  dec_alu_op;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, busy, halted;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [31:0] retired;
    exp_t        q[$];
    bit          done_flag = 0;

    cpu24_ctrl_fsm #(.MUL_LAT(LAT), .CNT_W(32)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .dec_reg_write(dec_reg_write),
      .dec_mem_read (dec_mem_read),
      .dec_mem_write(dec_mem_write),
      .dec_branch   (dec_branch),
      .dec_jump     (dec_jump),
      .dec_halt     (dec_halt),
      .dec_alu_op   (dec_alu_op),
      .alu_zero     (alu_zero),
      .imem_req     (imem_req),
      .ir_we        (ir_we),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .rf_we        (rf_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .state        (state),
      .busy         (busy),
      .halted       (halted),
      .retired      (retired)
    );

    // Driver: inputs change 1 time unit after each rising edge.
    initial begin : drv
      instr_t ins;
      int     ret, iw_left, dw_left, guard;
      bit     fin, abort, was_reset, hit_halt;
      rst = 1; start = 0; imem_ready = 0; dmem_ready = 0; alu_zero = 0;
      {dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt} = '0;
      dec_alu_op = 3'd0;
      ret = 0;
      @(posedge clk); #1;
      rst = 0;
      for (int s = 0; s < SESSIONS; s++) begin
        was_reset = 0;
        hit_halt  = 0;
        repeat ($urandom_range(0, 2)) begin
          imem_ready = 1'($urandom_range(0, 1));
          dmem_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int n = 0; n < N_PER; n++) begin
          if (s == 0) ins = directed(n);
          else        ins = rand_instr();
          abort = (s % 2 == 1) && (n == ABORT_AT);
          if (abort) begin
            ins.mw = 1; ins.mr = 0; ins.br = 0; ins.jp = 0; ins.hl = 0; ins.dw = 3;
          end
          {dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt} =
            {ins.rw, ins.mr, ins.mw, ins.br, ins.jp, ins.hl};
          dec_alu_op = ins.op;
          alu_zero   = ins.z;
          q.push_back(model(ins, LAT, ret));
          iw_left = ins.iw;
          dw_left = ins.dw;
          fin     = 0;
          guard   = 0;
          while (!fin && !was_reset) begin
            if (abort && state == ST_MEM) begin
              rst = 1; start = 1; imem_ready = 1; dmem_ready = 1;
              @(posedge clk); #1;
              rst = 0; start = 0; ret = 0;
              was_reset = 1;
            end else begin
              if (imem_req) begin
                imem_ready = (iw_left == 0);
                if (iw_left > 0) iw_left--;
              end else begin
                imem_ready = 1'($urandom_range(0, 1));
              end
              if (dmem_req) begin
                dmem_ready = (dw_left == 0);
                if (dw_left > 0) dw_left--;
              end else begin
                dmem_ready = 1'($urandom_range(0, 1));
              end
              start = ($urandom_range(0, 3) == 0);
              #1;
              fin = (pc_we === 1'b1) || (state == ST_DECODE && dec_halt);
              @(posedge clk); #1;
              guard++;
              if (!fin && guard > GUARD) begin
                check($sformatf("L%0d instr_timeout", LAT), guard, GUARD);
                rst = 1; start = 0;
                @(posedge clk); #1;
                rst = 0; ret = 0;
                was_reset = 1;
              end
            end
          end
          if (was_reset) break;
          ret++;
          if (ins.hl) begin
            hit_halt = 1;
            break;
          end
        end
        if (hit_halt) begin
          repeat (6) begin
            start      = 1'($urandom_range(0, 1));
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
          start = 0;
        end
        if (!was_reset) begin
          rst = 1;
          @(posedge clk); #1;
          rst = 0; ret = 0;
        end
      end
      repeat (2) @(posedge clk);
      done_flag = 1;
    end

    // Monitor: samples on the falling edge and scores each retire against the queue.
    initial begin : mon
      int   cyc, im_n, ir_n, dm_n, dw_n, rf_n, halt_ret;
      bit   post, in_halt;
      exp_t e;
      cyc = 0; im_n = 0; ir_n = 0; dm_n = 0; dw_n = 0; rf_n = 0;
      post = 0; in_halt = 0; halt_ret = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          check($sformatf("L%0d rst_priority_strobes", LAT), {pc_we, rf_we, ir_we}, 0);
          q.delete();
          cyc = 0; im_n = 0; ir_n = 0; dm_n = 0; dw_n = 0; rf_n = 0;
          post = 1; in_halt = 0;
          continue;
        end
        if (post) begin
          check($sformatf("L%0d reset_outputs", LAT),
                {state, busy, halted, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel}, 0);
          check($sformatf("L%0d reset_retired", LAT), retired, 0);
          post = 0;
        end
        if (in_halt) begin
          check($sformatf("L%0d halt_hold", LAT),
                {state, busy, halted, pc_we, ir_we, imem_req, dmem_req},
                {ST_HALTED, 1'b0, 1'b1, 4'b0000});
          check($sformatf("L%0d halt_retired", LAT), retired, halt_ret);
        end
        if (busy) begin
          cyc++;
          if (imem_req) im_n++;
          if (ir_we) ir_n++;
          if (dmem_req) dm_n++;
          if (dmem_req && dmem_we) dw_n++;
          if (rf_we) rf_n++;
          if (pc_we) begin
            if (q.size() == 0) begin
              check($sformatf("L%0d unexpected_retire", LAT), 1, 0);
            end else begin
              e = q.pop_front();
              check($sformatf("L%0d halt_pc_we", LAT), 0, e.is_halt);
              check($sformatf("L%0d cycles", LAT), cyc, e.cycles);
              check($sformatf("L%0d pc_sel", LAT), pc_sel, e.sel);
              check($sformatf("L%0d imem_req_cycles", LAT), im_n, e.im);
              check($sformatf("L%0d ir_we_count", LAT), ir_n, 1);
              check($sformatf("L%0d dmem_req_cycles", LAT), dm_n, e.dm);
              check($sformatf("L%0d dmem_we_cycles", LAT), dw_n, e.dwe ? e.dm : 0);
              check($sformatf("L%0d rf_we_count", LAT), rf_n, e.rf);
              check($sformatf("L%0d rf_we_in_last", LAT), rf_we, e.rf);
              check($sformatf("L%0d retired", LAT), retired, e.ret_prev);
            end
            cyc = 0; im_n = 0; ir_n = 0; dm_n = 0; dw_n = 0; rf_n = 0;
          end
        end else if (halted && cyc > 0) begin
          if (q.size() == 0) begin
            check($sformatf("L%0d unexpected_halt", LAT), 1, 0);
          end else begin
            e = q.pop_front();
            check($sformatf("L%0d halt_expected", LAT), 1, e.is_halt);
            check($sformatf("L%0d halt_cycles", LAT), cyc, e.cycles);
            check($sformatf("L%0d halt_imem_cycles", LAT), im_n, e.im);
            check($sformatf("L%0d halt_side_effects", LAT), dm_n + rf_n, 0);
            check($sformatf("L%0d halt_retire_once", LAT), retired, e.ret_prev + 1);
            halt_ret = e.ret_prev + 1;
          end
          in_halt = 1;
          cyc = 0; im_n = 0; ir_n = 0; dm_n = 0; dw_n = 0; rf_n = 0;
        end
      end
    end
  end

  initial begin
    wait (g_lane[0].done_flag && g_lane[1].done_flag);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
